rv_imm: RTL and testbench
=========================

RV_IMM -- requirements
Module: rv_imm

Interface
REQ-001 clk  input  1  Single clock; all state updates on the rising edge.
REQ-002 rst_n  input  1  Asynchronous, active-low reset.
REQ-003 in_valid  input  1  Marks inst as a new instruction to decode this cycle.
REQ-004 inst  input  32  RV32I instruction word.
REQ-005 imm  output  32  Registered, sign-extended immediate of the last accepted instruction.
REQ-006 fmt  output  3  Registered format code:
- 0 = none
- 1 = I
- 2 = S
- 3 = B
- 4 = U
- 5 = J
REQ-007 out_valid  output  1  High for exactly one cycle per accepted instruction, aligned with imm/fmt.

Function
REQ-008 Format is selected by opcode inst[6:0]:
- 0x03 load, 0x13 OP-IMM, 0x67 JALR, 0x73 SYSTEM -> I
- 0x23 -> S
- 0x63 -> B
- 0x37 LUI, 0x17 AUIPC -> U
- 0x6F -> J
- all other opcodes (including 0x33, 0x0F) -> none
REQ-009 I: imm = sign-extend(inst[31:20]).
REQ-010 S: imm = sign-extend({inst[31:25], inst[11:7]}).
REQ-011 B: imm = sign-extend({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}) (13 bits).
REQ-012 U: imm = {inst[31:12], 12'h000}; no further extension.
REQ-013 J: imm = sign-extend({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}) (21 bits).
REQ-014 Format none: imm = 0x00000000, fmt = 0.
REQ-015 OP-IMM shift forms (funct3 001/101) have no special treatment; imm is the full sign-extended inst[31:20] (SRAI 0x405 -> 0x00000405).
REQ-016 Sign bit is always inst[31] for I/S/B/J formats; funct3 and rd/rs fields never alter the result.
REQ-017 Latency is 1 cycle: an instruction with in_valid=1 at edge N yields imm/fmt at edge N and out_valid=1 until edge N+1.
REQ-018 in_valid=0 at an edge: out_valid goes 0; imm and fmt hold their previous values.
REQ-019 Back-to-back in_valid=1 on consecutive cycles: each result appears in order, one per cycle, with no bubbles.
REQ-020 No backpressure input; results are never stalled or dropped.

Reset
REQ-021 rst_n low forces, immediately and independent of clk:
- imm = 0x00000000
- fmt = 0
- out_valid = 0
REQ-022 Outputs stay at reset values while rst_n is low; in_valid is ignored.
REQ-023 First instruction is accepted on the first rising edge after rst_n deasserts.
REQ-024 Reset asserted mid-stream discards any pending result; no out_valid pulse follows the reset.

Verification
REQ-025 Back-to-back in_valid=1 stream, each -> imm/fmt/out_valid one cycle later:

| inst | imm | fmt |
|---|---|---|
| 0x000050B7 | 0x00005000 | 4 |
| 0x00000137 | 0x00000000 | 4 |
| 0x00508193 | 0x00000005 | 1 |
| 0x00502083 | 0x00000005 | 1 |
| 0xFE000CE3 | 0xFFFFFFF8 | 3 |
| 0x00077237 | 0x00077000 | 4 |
| 0x00C0D093 | 0x0000000C | 1 |
| 0xFF9FF2EF | 0xFFFFFFF8 | 5 |

REQ-026 S and negative I cases:
- inst = 0xFE112E23 -> imm = 0xFFFFFFFC, fmt = 2
- inst = 0xFFF00093 -> imm = 0xFFFFFFFF, fmt = 1
REQ-027 Unsupported opcode: inst = 0x002081B3 -> imm = 0x00000000, fmt = 0, out_valid = 1.
REQ-028 in_valid dropped for 3 cycles after a result -> out_valid = 0, imm/fmt unchanged.
REQ-029 rst_n pulsed low between clock edges during a stream -> outputs zero immediately, no result emitted for the in-flight instruction, normal operation resumes after release.

Source files
------------

// File: rtl/rv_imm_if.sv
// Decode request/response bundle between an instruction source and rv_imm.
interface rv_imm_if;
  logic        in_valid;
  logic [31:0] inst;
  logic [31:0] imm;
  logic [2:0]  fmt;
  logic        out_valid;

  modport master (output in_valid, output inst, input imm, input fmt, input out_valid);
  modport slave  (input in_valid, input inst, output imm, output fmt, output out_valid);
endinterface

// File: rtl/rv_imm.sv
// RV32I immediate extractor: classifies the opcode and registers the
// sign-extended immediate and format code one cycle after acceptance.
module rv_imm (
  input  logic   clk,
  input  logic   rst_n,
  rv_imm_if.slave bus
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned FMT_W = 3;

  localparam logic [FMT_W-1:0] FMT_NONE = 3'd0;
  localparam logic [FMT_W-1:0] FMT_I    = 3'd1;
  localparam logic [FMT_W-1:0] FMT_S    = 3'd2;
  localparam logic [FMT_W-1:0] FMT_B    = 3'd3;
  localparam logic [FMT_W-1:0] FMT_U    = 3'd4;
  localparam logic [FMT_W-1:0] FMT_J    = 3'd5;

  logic [XLEN-1:0]  imm_q, imm_d;
  logic [FMT_W-1:0] fmt_q, fmt_d;
  logic             valid_q, valid_d;

  logic [XLEN-1:0]  imm_c;
  logic [FMT_W-1:0] fmt_c;
  logic [31:0]      ins;

  assign ins = bus.inst;

  // Opcode classification and immediate reassembly; sign always from inst[31].
  always_comb begin
    imm_c = '0;
    fmt_c = FMT_NONE;
    unique case (ins[6:0])
      7'h03, 7'h13, 7'h67, 7'h73: begin
        fmt_c = FMT_I;
        imm_c = {{20{ins[31]}}, ins[31:20]};
      end
      7'h23: begin
        fmt_c = FMT_S;
        imm_c = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      end
      7'h63: begin
        fmt_c = FMT_B;
        imm_c = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      end
      7'h37, 7'h17: begin
        fmt_c = FMT_U;
        imm_c = {ins[31:12], 12'h000};
      end
      7'h6F: begin
        fmt_c = FMT_J;
        imm_c = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      end
      default: begin
        fmt_c = FMT_NONE;
        imm_c = '0;
      end
    endcase
  end

  // Capture on accept; otherwise hold imm/fmt and drop the valid pulse.
  always_comb begin
    imm_d   = imm_q;
    fmt_d   = fmt_q;
    valid_d = 1'b0;
    if (bus.in_valid) begin
      imm_d   = imm_c;
      fmt_d   = fmt_c;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imm_q   <= '0;
      fmt_q   <= FMT_NONE;
      valid_q <= 1'b0;
    end else begin
      imm_q   <= imm_d;
      fmt_q   <= fmt_d;
      valid_q <= valid_d;
    end
  end

  assign bus.imm       = imm_q;
  assign bus.fmt       = fmt_q;
  assign bus.out_valid = valid_q;

endmodule

// File: tb/tb_rv_imm.sv
// Directed bench for rv_imm: driver queues expected results, a negedge
// monitor pops and compares whenever out_valid is seen.
module tb_rv_imm;

  typedef struct packed {
    logic [31:0] imm;
    logic [2:0]  fmt;
  } exp_t;

  logic clk;
  logic rst_n;
  rv_imm_if bus ();

  rv_imm dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  logic [31:0] last_imm;
  logic [2:0]  last_fmt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: every out_valid must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: imm 0x%08h fmt %0d with empty queue at %0t",
                 bus.imm, bus.fmt, $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("imm", bus.imm, e.imm);
        check("fmt", 32'(bus.fmt), 32'(e.fmt));
      end
    end
  end

  // Driver: present one instruction for one edge, recording what should come back.
  task automatic send(input logic [31:0] i, input logic [31:0] e_imm, input logic [2:0] e_fmt);
    exp_t e;
    e.imm = e_imm;
    e.fmt = e_fmt;
    bus.in_valid = 1'b1;
    bus.inst     = i;
    exp_q.push_back(e);
    last_imm = e_imm;
    last_fmt = e_fmt;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_hold(input int n);
    bus.in_valid = 1'b0;
    bus.inst     = 32'hFFFF_FFFF;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      check("idle_valid", 32'(bus.out_valid), 32'd0);
      check("idle_imm", bus.imm, last_imm);
      check("idle_fmt", 32'(bus.fmt), 32'(last_fmt));
    end
  endtask

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish, got 0 expected 1");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "timeout");
  end

  initial begin
    rst_n        = 1'b0;
    bus.in_valid = 1'b1;
    bus.inst     = 32'h0050_8193;
    last_imm     = 32'h0;
    last_fmt     = 3'd0;

    // Reset state, with in_valid held high across edges to show it is ignored.
    #3;
    check("rst_imm", bus.imm, 32'h0);
    check("rst_fmt", 32'(bus.fmt), 32'd0);
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    check("rst_hold_imm", bus.imm, 32'h0);
    check("rst_hold_valid", 32'(bus.out_valid), 32'd0);
    bus.in_valid = 1'b0;
    rst_n = 1'b1;

    // Back-to-back stream.
    send(32'h0000_50B7, 32'h0000_5000, 3'd4);
    send(32'h0000_0137, 32'h0000_0000, 3'd4);
    send(32'h0050_8193, 32'h0000_0005, 3'd1);
    send(32'h0050_2083, 32'h0000_0005, 3'd1);
    send(32'hFE00_0CE3, 32'hFFFF_FFF8, 3'd3);
    send(32'h0007_7237, 32'h0007_7000, 3'd4);
    send(32'h00C0_D093, 32'h0000_000C, 3'd1);
    send(32'hFF9F_F2EF, 32'hFFFF_FFF8, 3'd5);

    // S, negative I, shift-immediate, JALR/SYSTEM, AUIPC, unsupported opcodes.
    send(32'hFE11_2E23, 32'hFFFF_FFFC, 3'd2);
    send(32'hFFF0_0093, 32'hFFFF_FFFF, 3'd1);
    send(32'h4050_D093, 32'h0000_0405, 3'd1);
    send(32'h8000_0067, 32'hFFFF_F800, 3'd1);
    send(32'h0010_0073, 32'h0000_0001, 3'd1);
    send(32'h8000_0017, 32'h8000_0000, 3'd4);
    send(32'h8000_006F, 32'hFFF0_0000, 3'd5);
    send(32'h0020_81B3, 32'h0000_0000, 3'd0);
    send(32'h7FF0_0063 | 32'h0000_0F80, 32'h0000_0FFE, 3'd3);
    send(32'h0000_100F, 32'h0000_0000, 3'd0);

    // Drop in_valid for 3 cycles after a result: outputs hold.
    send(32'hFE11_2E23, 32'hFFFF_FFFC, 3'd2);
    idle_hold(3);

    // Reset pulsed mid-cycle with an instruction in flight.
    send(32'h0050_8193, 32'h0000_0005, 3'd1);
    bus.in_valid = 1'b1;
    bus.inst     = 32'hFFF0_0093;
    #6;
    rst_n = 1'b0;
    #1;
    check("midrst_imm", bus.imm, 32'h0);
    check("midrst_fmt", 32'(bus.fmt), 32'd0);
    check("midrst_valid", 32'(bus.out_valid), 32'd0);
    @(posedge clk); #1;
    check("midrst_hold_imm", bus.imm, 32'h0);
    rst_n = 1'b1;
    bus.in_valid = 1'b0;
    last_imm = 32'h0;
    last_fmt = 3'd0;
    idle_hold(2);

    // Normal operation resumes.
    send(32'h0000_50B7, 32'h0000_5000, 3'd4);
    send(32'hFE00_0CE3, 32'hFFFF_FFF8, 3'd3);
    idle_hold(1);

    @(posedge clk); #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
